// File: rtl/dynamic_branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the dynamic branch predictor.
// GSHARE_EN adds the global-history ports ghr_f and update_ghr.
interface dynamic_branch_predictor_if #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6
);
   logic [DATA_WIDTH-1:0] RD;
   logic [DATA_WIDTH-1:0] PC_f;
   logic [DATA_WIDTH-1:0] branch_target;
   logic                  predict_taken;
   // update_valid is a one-cycle strobe with no back-pressure: the predictor
   // always accepts the resolution, and update_* are ignored while it is low.
   logic                  update_valid;
   logic                  update_is_cond;
   logic [DATA_WIDTH-1:0] update_pc;
   logic                  update_taken;
   logic [DATA_WIDTH-1:0] update_target;
`ifdef GSHARE_EN
   logic [INDEX_BITS-1:0] ghr_f;
   logic [INDEX_BITS-1:0] update_ghr;

   modport master (
      output RD, PC_f, update_valid, update_is_cond, update_pc, update_taken,
             update_target, update_ghr,
      input  branch_target, predict_taken, ghr_f
   );
   modport slave (
      input  RD, PC_f, update_valid, update_is_cond, update_pc, update_taken,
             update_target, update_ghr,
      output branch_target, predict_taken, ghr_f
   );
`else
   modport master (
      output RD, PC_f, update_valid, update_is_cond, update_pc, update_taken,
             update_target,
      input  branch_target, predict_taken
   );
   modport slave (
      input  RD, PC_f, update_valid, update_is_cond, update_pc, update_taken,
             update_target,
      output branch_target, predict_taken
   );
`endif
endinterface

// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and static BTFN fallback on a miss.
// Optional gshare indexing of conditional branches is enabled by defining GSHARE_EN.
module dynamic_branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dynamic_branch_predictor_if.slave bus
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];

   logic [6:0]            opcode;
   logic [INDEX_BITS-1:0] pc_idx, cond_idx, upd_idx;
   logic [TAG_BITS-1:0]   pc_tag, upd_tag;
   logic [DATA_WIDTH-1:0] b_imm, j_imm, pc_plus4;
   logic                  cond_hit, jalr_hit, upd_hit;
   logic [1:0]            upd_ctr;
   logic                  unused_upd_bits;

   assign opcode   = bus.RD[6:0];
   assign pc_idx   = bus.PC_f[INDEX_BITS+1:2];
   assign pc_tag   = bus.PC_f[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign upd_tag  = bus.update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
   assign pc_plus4 = bus.PC_f + DATA_WIDTH'(4);
   assign b_imm = {{(DATA_WIDTH-12){bus.RD[31]}}, bus.RD[7], bus.RD[30:25], bus.RD[11:8], 1'b0};
   assign j_imm = {{(DATA_WIDTH-20){bus.RD[31]}}, bus.RD[19:12], bus.RD[20], bus.RD[30:21], 1'b0};
   assign unused_upd_bits = ^{bus.update_pc[1:0], bus.update_pc[DATA_WIDTH-1:INDEX_BITS+TAG_BITS+2]};

`ifdef GSHARE_EN
   logic [INDEX_BITS-1:0] ghr_q;

   assign bus.ghr_f = ghr_q;
   assign cond_idx  = pc_idx ^ ghr_q;
   assign upd_idx   = bus.update_pc[INDEX_BITS+1:2] ^
                      (bus.update_is_cond ? bus.update_ghr : '0);
`else
   assign cond_idx  = pc_idx;
   assign upd_idx   = bus.update_pc[INDEX_BITS+1:2];
`endif

   assign cond_hit = valid_q[cond_idx] && (tag_q[cond_idx] == pc_tag);
   assign jalr_hit = valid_q[pc_idx]   && (tag_q[pc_idx]   == pc_tag);
   assign upd_hit  = valid_q[upd_idx]  && (tag_q[upd_idx]  == upd_tag);

   // Lookup reads the array combinationally, so a same-cycle update is not yet visible.
   always_comb begin
      bus.predict_taken = 1'b0;
      bus.branch_target = pc_plus4;
      if (rst_n) begin
         case (opcode)
            OP_BRANCH: begin
               bus.branch_target = bus.PC_f + b_imm;
               bus.predict_taken = cond_hit ? ctr_q[cond_idx][1]
                                            : (bus.branch_target < bus.PC_f);
            end
            OP_JAL: begin
               bus.branch_target = bus.PC_f + j_imm;
               bus.predict_taken = 1'b1;
            end
            OP_JALR: begin
               if (jalr_hit) begin
                  bus.branch_target = target_q[pc_idx];
                  bus.predict_taken = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Unconditional jumps never train the counter on a hit, but seed it weakly taken on allocate.
   always_comb begin
      upd_ctr = ctr_q[upd_idx];
      if (bus.update_is_cond) begin
         if (!upd_hit)
            upd_ctr = bus.update_taken ? 2'b10 : 2'b01;
         else if (bus.update_taken && (ctr_q[upd_idx] != 2'b11))
            upd_ctr = ctr_q[upd_idx] + 2'b01;
         else if (!bus.update_taken && (ctr_q[upd_idx] != 2'b00))
            upd_ctr = ctr_q[upd_idx] - 2'b01;
      end else if (!upd_hit) begin
         upd_ctr = 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (bus.update_valid) begin
         valid_q[upd_idx]  <= 1'b1;
         tag_q[upd_idx]    <= upd_tag;
         target_q[upd_idx] <= bus.update_target;
         ctr_q[upd_idx]    <= upd_ctr;
      end
   end

`ifdef GSHARE_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         ghr_q <= '0;
      else if (bus.update_valid && bus.update_is_cond)
         ghr_q <= {ghr_q[INDEX_BITS-2:0], bus.update_taken};
   end
`endif
endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Directed bench for dynamic_branch_predictor: a table-based BTB model checked every
// cycle, plus hand-computed expectations along the training sequence.
module tb_dynamic_branch_predictor;
   localparam int IB = 6;
   localparam int TB_BITS = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   started = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   dynamic_branch_predictor_if #(.DATA_WIDTH(32), .INDEX_BITS(IB)) bus ();

   dynamic_branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(IB), .TAG_BITS(TB_BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // ---------------- model: a table indexed by PC word address ----------------
   bit          m_valid [1 << IB];
   int          m_tag   [1 << IB];
   logic [31:0] m_tgt   [1 << IB];
   int          m_ctr   [1 << IB];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 4) % (1 << IB));
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc / (4 << IB)) % (1 << TB_BITS));
   endfunction

   function automatic void model_predict(input logic [31:0] rd, pc, input bit in_reset,
                                         output bit t, output logic [31:0] tgt,
                                         output bit chk_tgt);
      int i;
      bit hit;
      logic [31:0] imm;
      i = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      t = 1'b0;
      tgt = pc + 32'd4;
      chk_tgt = 1'b1;
      if (!in_reset) begin
         if (rd[6:0] == 7'b1100011) begin
            imm = {{20{rd[31]}}, rd[7], rd[30:25], rd[11:8], 1'b0};
            tgt = pc + imm;
            t = hit ? (m_ctr[i] >= 2) : (tgt < pc);
         end else if (rd[6:0] == 7'b1101111) begin
            imm = {{12{rd[31]}}, rd[19:12], rd[20], rd[30:21], 1'b0};
            tgt = pc + imm;
            t = 1'b1;
         end else if (rd[6:0] == 7'b1100111) begin
            t = hit;
            if (hit) tgt = m_tgt[i];
            else chk_tgt = 1'b0;
         end
      end
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < (1 << IB); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = '0;
            m_ctr[i] = 1;
         end
      end else if (bus.update_valid) begin
         int i;
         bit hit;
         i = idx_of(bus.update_pc);
         hit = m_valid[i] && (m_tag[i] == tag_of(bus.update_pc));
         if (bus.update_is_cond) begin
            if (!hit) m_ctr[i] = bus.update_taken ? 2 : 1;
            else if (bus.update_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end else if (!hit) begin
            m_ctr[i] = 2;
         end
         m_valid[i] = 1'b1;
         m_tag[i] = tag_of(bus.update_pc);
         m_tgt[i] = bus.update_target;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (started) begin
         bit et, ct;
         logic [31:0] etg;
         model_predict(bus.RD, bus.PC_f, !rst_n, et, etg, ct);
         total_cnt++;
         if (bus.predict_taken !== et)
            $display("FAIL model_taken pc=%h rd=%h: got %0b need %0b", bus.PC_f, bus.RD, bus.predict_taken, et);
         else
            pass_cnt++;
         if (ct) begin
            total_cnt++;
            if (bus.branch_target !== etg)
               $display("FAIL model_target pc=%h rd=%h: got %h need %h", bus.PC_f, bus.RD, bus.branch_target, etg);
            else
               pass_cnt++;
         end
      end
   end

   // ---------------- encoders and driver tasks ----------------
   function automatic logic [31:0] enc_b(input int imm);
      logic [12:0] i;
      i = imm[12:0];
      return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_jal(input int imm);
      logic [20:0] i;
      i = imm[20:0];
      return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr();
      return {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
   endfunction

   task automatic cyc(input logic [31:0] rd, pc, input bit uv, uc, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input string name,
                      input bit chk, et, input logic [31:0] etgt, input bit ctgt);
      bus.RD = rd;
      bus.PC_f = pc;
      bus.update_valid = uv;
      bus.update_is_cond = uc;
      bus.update_pc = upc;
      bus.update_taken = ut;
      bus.update_target = utgt;
      @(negedge clk);
      #1;
      if (chk) begin
         total_cnt++;
         if (bus.predict_taken !== et)
            $display("FAIL %s taken: got %0b need %0b", name, bus.predict_taken, et);
         else
            pass_cnt++;
         if (ctgt) begin
            total_cnt++;
            if (bus.branch_target !== etgt)
               $display("FAIL %s target: got %h need %h", name, bus.branch_target, etgt);
            else
               pass_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] rd, pc, input string name, input bit et,
                       input logic [31:0] etgt, input bit ctgt);
      cyc(rd, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, name, 1'b1, et, etgt, ctgt);
   endtask

   task automatic upd(input bit uc, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
      cyc(NOP, 32'h1000, 1'b1, uc, upc, ut, utgt, "upd", 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
`ifdef GSHARE_EN
      bus.update_ghr = '0;
`endif
      rst_n = 1'b0;
      look(enc_b(-16), 32'h100, "in_reset", 1'b0, 32'h104, 1'b1);
      started = 1'b1;
      look(enc_b(-16), 32'h100, "in_reset2", 1'b0, 32'h104, 1'b1);
      rst_n = 1'b1;

      look(enc_b(-16), 32'h100, "btfn_back", 1'b1, 32'h0F0, 1'b1);
      look(enc_b(16),  32'h100, "btfn_fwd",  1'b0, 32'h110, 1'b1);

      upd(1'b1, 32'h200, 1'b1, 32'h208);
      look(enc_b(8), 32'h200, "ctr10", 1'b1, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b1, 32'h208);
      look(enc_b(8), 32'h200, "ctr11", 1'b1, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "ctr11_nt_10", 1'b1, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "ctr01", 1'b0, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "ctr00", 1'b0, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      upd(1'b1, 32'h200, 1'b1, 32'h208);
      look(enc_b(8), 32'h200, "sat_low", 1'b0, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b1, 32'h208);
      upd(1'b1, 32'h200, 1'b1, 32'h208);
      upd(1'b1, 32'h200, 1'b1, 32'h208);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "sat_high", 1'b1, 32'h208, 1'b1);
      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "sat_high_nt2", 1'b0, 32'h208, 1'b1);

      look(enc_jalr(), 32'h304, "jalr_miss", 1'b0, 32'h0, 1'b0);
      upd(1'b0, 32'h304, 1'b1, 32'h480);
      look(enc_jalr(), 32'h304, "jalr_hit", 1'b1, 32'h480, 1'b1);
      look(enc_jal(256), 32'h400, "jal_fwd", 1'b1, 32'h500, 1'b1);
      look(enc_jal(-8),  32'h400, "jal_back", 1'b1, 32'h3F8, 1'b1);
      look(NOP, 32'h500, "other_op", 1'b0, 32'h504, 1'b1);
      upd(1'b0, 32'h608, 1'b1, 32'h700);
      look(enc_b(8), 32'h608, "jal_alloc_ctr10", 1'b1, 32'h610, 1'b1);

      upd(1'b1, 32'h200, 1'b1, 32'h208);
      look(enc_b(8), 32'h200, "pre_alias", 1'b1, 32'h208, 1'b1);
      upd(1'b1, 32'h300, 1'b1, 32'h308);
      look(enc_b(8), 32'h200, "alias_miss", 1'b0, 32'h208, 1'b1);
      look(enc_b(8), 32'h300, "alias_new", 1'b1, 32'h308, 1'b1);

      upd(1'b1, 32'h200, 1'b0, 32'h208);
      look(enc_b(8), 32'h200, "realloc01", 1'b0, 32'h208, 1'b1);
      cyc(enc_b(8), 32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h208, "same_cycle_old",
          1'b1, 1'b0, 32'h208, 1'b1);
      look(enc_b(8), 32'h200, "same_cycle_next", 1'b1, 32'h208, 1'b1);
      cyc(NOP, 32'h1000, 1'b0, 1'b1, 32'h200, 1'b0, 32'h999, "idle_upd",
          1'b0, 1'b0, 32'h0, 1'b0);
      cyc(NOP, 32'h1000, 1'b0, 1'b1, 32'h200, 1'b0, 32'h999, "idle_upd",
          1'b0, 1'b0, 32'h0, 1'b0);
      look(enc_b(8), 32'h200, "ignored_upd", 1'b1, 32'h208, 1'b1);

      rst_n = 1'b0;
      look(enc_b(8), 32'h200, "mid_reset", 1'b0, 32'h204, 1'b1);
      look(enc_jalr(), 32'h304, "mid_reset_jalr", 1'b0, 32'h308, 1'b1);
      rst_n = 1'b1;
      look(enc_b(8), 32'h200, "post_reset_fwd", 1'b0, 32'h208, 1'b1);
      look(enc_jalr(), 32'h304, "post_reset_jalr", 1'b0, 32'h0, 1'b0);
      look(enc_b(-16), 32'h200, "post_reset_back", 1'b1, 32'h1F0, 1'b1);

      @(negedge clk);
      started = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
